// File: rtl/conv11_pw_accum.sv
// Purpose : 1x1 (pointwise) convolution for one output pixel of one output channel.
//           Accumulates IN_CH activation*weight pairs, adds bias, requantises by a
//           Q(FRAC_BITS) scale with round-half-up, optional ReLU, saturates to DATA_WIDTH.
// Latency : out_valid rises on the 2nd rising edge after the edge accepting the last pair.
// Backpr. : in_ready is high only in IDLE/ACC; the result is held in OUT until out_ready.
// Ports   : clk/rst_n (async active-low); in_valid/in_ready/in_data/in_weight pair stream;
//           bias/scale/relu_en sampled with the first pair; out_valid/out_ready/out_data
//           result stream; busy high whenever the engine is not idle.
module conv11_pw_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int BIAS_WIDTH = 32,
  parameter int IN_CH      = 16,
  parameter int FRAC_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic signed [BIAS_WIDTH-1:0] scale,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy
);

  localparam int CNT_W  = $clog2(IN_CH + 1);
  localparam int PP_W   = 2 * DATA_WIDTH;
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = SUM_W + BIAS_WIDTH;
  // One spare bit so adding the rounding constant can never wrap.
  localparam int RND_W  = PROD_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_CH);
  localparam logic signed [RND_W-1:0] HALF    = RND_W'(longint'(1) << (FRAC_BITS - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((longint'(1) << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(longint'(1) << (DATA_WIDTH - 1)));
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_BIAS,
    S_SCALE,
    S_OUT
  } state_t;

  state_t                         state_q;
  logic        [CNT_W-1:0]        cnt_q;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [BIAS_WIDTH-1:0]   bias_q;
  logic signed [BIAS_WIDTH-1:0]   scale_q;
  logic                           relu_q;
  logic signed [SUM_W-1:0]        sum_q;
  logic                           out_valid_q;
  logic signed [DATA_WIDTH-1:0]   out_data_q;

  logic signed [PP_W-1:0]         pair_prod;
  logic        [CNT_W-1:0]        cnt_d;
  logic signed [SUM_W-1:0]        sum_d;
  logic signed [PROD_W-1:0]       prod;
  logic signed [RND_W-1:0]        rnd;
  logic signed [RND_W-1:0]        shifted;
  logic signed [DATA_WIDTH-1:0]   res_d;

  // Size casts of signed operands sign-extend, so every stage is exact.
  always_comb begin
    pair_prod = PP_W'(in_data) * PP_W'(in_weight);
    cnt_d     = cnt_q + CNT_W'(1);
    sum_d     = SUM_W'(acc_q) + SUM_W'(bias_q);
    prod      = PROD_W'(sum_q) * PROD_W'(scale_q);
    rnd       = RND_W'(prod) + HALF;
    shifted   = rnd >>> FRAC_BITS;
    if (relu_q && (shifted < 0)) begin
      shifted = '0;
    end
    if (shifted > SAT_MAX) begin
      res_d = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      res_d = OUT_MIN;
    end else begin
      res_d = shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      scale_q     <= '0;
      relu_q      <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // First pair loads (not adds) so no clear cycle is needed between pixels.
            acc_q   <= ACC_WIDTH'(pair_prod);
            bias_q  <= bias;
            scale_q <= scale;
            relu_q  <= relu_en;
            cnt_q   <= CNT_W'(1);
            state_q <= (IN_CH == 1) ? S_BIAS : S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            acc_q <= acc_q + ACC_WIDTH'(pair_prod);
            if (cnt_d == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= S_BIAS;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        S_BIAS: begin
          sum_q   <= sum_d;
          cnt_q   <= '0;
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv11_pw_accum.sv
// Purpose : self-checking bench for conv11_pw_accum (IN_CH=4, FRAC_BITS=16).
// Latency : expected results are queued at stimulus time and popped on each output handshake.
// Backpr. : exercises input gaps, output stalls, back-to-back pixels and mid-pixel reset.
module tb_conv11_pw_accum;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int BW  = 32;
  localparam int NCH = 4;
  localparam int FB  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] in_weight;
  logic signed [BW-1:0] bias;
  logic signed [BW-1:0] scale;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 busy;

  always #5 clk = ~clk;

  conv11_pw_accum #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW), .IN_CH(NCH), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .bias(bias), .scale(scale), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     hs_cyc   = 0;
  longint exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        longint e;
        e = exp_q.pop_front();
        check("pixel_result", longint'(out_data), e);
      end
    end
  end

  function automatic longint model(input int d[NCH], input int w[NCH], input int b,
                                   input int s, input bit relu);
    longint acc, p, r;
    acc = 0;
    for (int i = 0; i < NCH; i++) acc += longint'(d[i]) * longint'(w[i]);
    p = (acc + longint'(b)) * longint'(s);
    r = (p + (longint'(1) << (FB - 1))) >>> FB;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic beat(input int d, input int w);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_data   = DW'(d);
    in_weight = DW'(w);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns right after the edge that accepts the last pair.
  task automatic send_pixel(input int d[NCH], input int w[NCH], input int b, input int s,
                            input bit relu, input int gap, input bit chk_b2b,
                            input longint expv);
    exp_q.push_back(expv);
    bias    = BW'(b);
    scale   = BW'(s);
    relu_en = relu;
    for (int i = 0; i < NCH; i++) begin
      beat(d[i], w[i]);
      if (i == 0) begin
        if (chk_b2b) check("b2b_first_beat_edge", cyc, hs_cyc + 1);
        // Must not influence the pixel already in flight.
        bias    = $urandom;
        scale   = $urandom;
        relu_en = ~relu;
      end
      if (i < NCH - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d[NCH], w[NCH];
    int td[7], tw[7], tb[7], ts[7], te[7];
    bit tr[7];
    int n, b, s;
    bit r;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0;
    bias = '0; scale = '0; relu_en = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic pixel with latency checks.
    d = '{10, 10, 10, 10}; w = '{2, 2, 2, 2};
    send_pixel(d, w, 20, 65536, 1'b1, 0, 1'b0, 100);
    check("lat_e0_out_valid", out_valid, 0);
    check("lat_e0_busy", busy, 1);
    check("lat_e0_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("lat_e1_out_valid", out_valid, 0);
    check("lat_e1_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("lat_e2_out_valid", out_valid, 1);
    wait_drain();

    // Saturation, ReLU and rounding table.
    td = '{127, -128, -10, -10, 0, 0, 0};
    tw = '{127, 127, 2, 2, 0, 0, 0};
    tb = '{0, 0, 0, 0, 3, -3, 1};
    ts = '{65536, 65536, 65536, 65536, 32768, 32768, 16384};
    tr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    te = '{127, -128, 0, -80, 2, -1, 0};
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < NCH; i++) begin
        d[i] = td[k];
        w[i] = tw[k];
      end
      send_pixel(d, w, tb[k], ts[k], tr[k], 0, 1'b0, longint'(te[k]));
      wait_drain();
    end

    // Gapped input (valid 1,0,0,1,...).
    d = '{10, 10, 10, 10}; w = '{2, 2, 2, 2};
    send_pixel(d, w, 20, 65536, 1'b1, 2, 1'b0, 100);
    wait_drain();

    // Output stall: result and in_ready held while out_ready is low.
    out_ready = 1'b0;
    d = '{3, 3, 3, 3}; w = '{-5, -5, -5, -5};
    send_pixel(d, w, 7, 65536, 1'b0, 0, 1'b0, -53);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, -53);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back pixels: next first pair accepted on the edge after the handshake.
    d = '{1, 1, 1, 1}; w = '{1, 1, 1, 1};
    send_pixel(d, w, 0, 65536, 1'b0, 0, 1'b0, 4);
    d = '{2, 2, 2, 2}; w = '{3, 3, 3, 3};
    send_pixel(d, w, 1, 65536, 1'b0, 0, 1'b1, 25);
    wait_drain();

    // Reset after 2 of 4 pairs: outputs clear without a clock, no residue afterwards.
    bias = 5; scale = 65536; relu_en = 1'b0;
    beat(50, 2);
    beat(50, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    #7;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = '{10, 10, 10, 10}; w = '{2, 2, 2, 2};
    send_pixel(d, w, 20, 65536, 1'b1, 0, 1'b0, 100);
    wait_drain();

    // Random pixels against the reference model.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NCH; i++) begin
        d[i] = int'($urandom_range(0, 255)) - 128;
        w[i] = int'($urandom_range(0, 255)) - 128;
      end
      b = int'($urandom_range(0, 4000)) - 2000;
      s = int'($urandom_range(100, 70000));
      r = 1'($urandom_range(0, 1));
      send_pixel(d, w, b, s, r, int'($urandom_range(0, 1)), 1'b0, model(d, w, b, s, r));
      wait_drain();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv11_pw_accum.md
Name: conv11_pw_accum

Overview:
- Parametrised pointwise (1x1) convolution engine for one output pixel of one output channel.
- Serially accepts IN_CH (activation, weight) pairs over a valid/ready stream and accumulates them.
- Then adds bias, requantises by a Q-format scale with round-half-up, applies optional ReLU and saturates to DATA_WIDTH.
- Sits between the feature-map/weight buffers and the output line buffer, with valid/ready on both sides.

Parameters:
- DATA_WIDTH, 8: signed width of activation, weight and result.
- ACC_WIDTH, 32: signed accumulator width; must be at least 2*DATA_WIDTH+clog2(IN_CH).
- BIAS_WIDTH, 32: signed width of bias and scale.
- IN_CH, 16: input channels per pixel (1..1024).
- FRAC_BITS, 16: fractional bits of scale; right-shift amount at requantisation (1..31).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pair valid
- in_ready  out  1  engine can accept pair
- in_data  in  DATA_WIDTH  signed activation
- in_weight  in  DATA_WIDTH  signed weight
- bias  in  BIAS_WIDTH  signed bias, accumulator scale
- scale  in  BIAS_WIDTH  signed multiplier, FRAC_BITS fractional bits
- relu_en  in  1  1 = clamp negatives to 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  signed requantised result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, channel counter=0, accumulator=0, out_valid=0, out_data=0, busy=0. in_ready is 1 after reset.
- States: IDLE, ACC, BIAS, SCALE, OUT.
- in_ready=1 only in IDLE and ACC. A beat is accepted on a rising edge with in_valid&&in_ready.
- IDLE:
  - On an accepted beat: accumulator = in_data*in_weight (sign-extended). Register bias, scale and relu_en. Counter=1.
  - Go to ACC, or to BIAS if IN_CH=1.
  - With no accepted beat, stay in IDLE.
- ACC:
  - Each accepted beat adds the signed product to the accumulator and increments the counter.
  - The beat that makes counter==IN_CH moves to BIAS and clears the counter.
  - Gaps (in_valid=0) stall without side effects.
- BIAS, one cycle: sum = accumulator + sign-extended registered bias. Width is ACC_WIDTH+1, with no wrap.
- SCALE, one cycle:
  - prod = sum * registered scale, full width.
  - r = (prod + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift.
  - If relu_en and r<0, r=0.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register it into out_data.
- OUT:
  - out_valid=1 and out_data stable until out_valid&&out_ready.
  - On that edge: out_valid=0 and state=IDLE.
- Latency: out_valid rises on the 2nd rising edge after the edge accepting the last beat. With out_ready held at 1, a new pixel's first beat can be accepted on the edge after the handshake.
- Input and output do not overlap: in_ready=0 during BIAS, SCALE and OUT.
- bias, scale and relu_en changing after the first beat have no effect on the current pixel.
- Reset mid-operation discards the partial accumulation; no out_valid is produced for that pixel.
- Accumulator overflow cannot occur when the ACC_WIDTH rule is met; the RTL does not check it.

Test Plan (IN_CH=4, FRAC_BITS=16):
- Basic: 4 beats data=10, weight=2, bias=20, scale=65536, relu_en=1 -> out_data=100. out_valid rises on the 2nd edge after the last accepted beat.
- Saturation:
  - data=127, weight=127 x4, bias=0, scale=65536 -> 127.
  - data=-128, weight=127 x4, relu_en=0 -> -128.
- ReLU: data=-10, weight=2 x4, bias=0, scale=65536.
  - relu_en=1 -> 0.
  - relu_en=0 -> -80.
- Rounding: all data=0.
  - bias=3, scale=32768 -> 2.
  - bias=-3, scale=32768 -> -1.
  - bias=1, scale=16384 -> 0.
- Handshake:
  - in_valid toggled 1,0,0,1,... -> same result as back-to-back beats.
  - out_ready=0 for 5 cycles -> out_valid and out_data held; in_ready=0 throughout.
  - Handshake, then next pixel's first beat accepted on the following edge.
- Reset: rst_n pulsed low after 2 of 4 beats.
  - Outputs return to reset values immediately, without a clock.
  - The next full 4-beat pixel gives the correct result with no residue.
